// File: rtl/restoring_divider_n_if.sv
// Divider request/response bundle.
// The pipeline drives the master side; the divider is the slave.
interface restoring_divider_n_if #(
  parameter int N = 32
);
  logic         i_Start;
  logic         i_Signed;
  logic [N-1:0] i_Dividend;
  logic [N-1:0] i_Divisor;
  logic         o_Busy;
  logic         o_Done;
  logic [N-1:0] o_Quotient;
  logic [N-1:0] o_Remainder;
  logic         o_DivByZero;

  modport master (
    output i_Start,
    output i_Signed,
    output i_Dividend,
    output i_Divisor,
    input  o_Busy,
    input  o_Done,
    input  o_Quotient,
    input  o_Remainder,
    input  o_DivByZero
  );

  modport slave (
    input  i_Start,
    input  i_Signed,
    input  i_Dividend,
    input  i_Divisor,
    output o_Busy,
    output o_Done,
    output o_Quotient,
    output o_Remainder,
    output o_DivByZero
  );
endinterface

// File: rtl/restoring_divider_n.sv
// Multi-cycle restoring divider, one shift-subtract step per clock.
// Signed operands run as magnitudes and are sign-corrected in FIXUP.
module restoring_divider_n #(
  parameter int N = 32
) (
  input  logic                 i_Clock,
  input  logic                 i_Reset,
  restoring_divider_n_if.slave bus
);

  localparam int CW = $clog2(N + 1);
  localparam logic [N-1:0] MIN_NEG = {1'b1, {(N-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIXUP,
    DONE
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [N-1:0]  q_reg;
  logic [N-1:0]  d_reg;
  // Restored remainder is always below D, so N bits hold it;
  // the shifted value and the trial difference use N+1 bits.
  logic [N-1:0]  r_reg;
  logic [CW-1:0] cnt;
  logic          sq;
  logic          sr;
  logic          dbz;

  logic          accept;
  logic          early;
  logic          div_zero;
  logic          ovf;
  logic          a_neg;
  logic          b_neg;
  logic [N-1:0]  a_mag;
  logic [N-1:0]  b_mag;
  logic [N:0]    r_shift;
  logic [N:0]    t_diff;

  // Accept decode, early-exit detection and one restoring step.
  always_comb begin
    accept   = 1'b0;
    a_neg    = 1'b0;
    b_neg    = 1'b0;
    div_zero = 1'b0;
    ovf      = 1'b0;
    early    = 1'b0;
    a_mag    = bus.i_Dividend;
    b_mag    = bus.i_Divisor;
    r_shift  = {r_reg, q_reg[N-1]};
    t_diff   = r_shift - {1'b0, d_reg};
    accept   = bus.i_Start &&
               (state == IDLE || state == DONE);
    a_neg    = bus.i_Signed & bus.i_Dividend[N-1];
    b_neg    = bus.i_Signed & bus.i_Divisor[N-1];
    if (a_neg) a_mag = -bus.i_Dividend;
    if (b_neg) b_mag = -bus.i_Divisor;
    div_zero = (bus.i_Divisor == '0);
    ovf      = bus.i_Signed &&
               (bus.i_Dividend == MIN_NEG) &&
               (bus.i_Divisor == '1);
    early    = div_zero | ovf;
  end

  // State register.
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next-state logic and handshake outputs.
  always_comb begin
    state_nxt  = state;
    bus.o_Busy = 1'b0;
    bus.o_Done = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) state_nxt = early ? FIXUP : RUN;
      end
      RUN: begin
        bus.o_Busy = 1'b1;
        if (cnt == CW'(1)) state_nxt = FIXUP;
      end
      FIXUP: begin
        bus.o_Busy = 1'b1;
        state_nxt  = DONE;
      end
      DONE: begin
        bus.o_Done = 1'b1;
        if (accept) state_nxt = early ? FIXUP : RUN;
        else        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand latch, iteration datapath and result registers.
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      q_reg           <= '0;
      d_reg           <= '0;
      r_reg           <= '0;
      cnt             <= '0;
      sq              <= 1'b0;
      sr              <= 1'b0;
      dbz             <= 1'b0;
      bus.o_Quotient  <= '0;
      bus.o_Remainder <= '0;
      bus.o_DivByZero <= 1'b0;
    end else if (accept) begin
      cnt <= CW'(N);
      d_reg <= b_mag;
      if (div_zero) begin
        // Fixed result; sign flags off so FIXUP passes it through.
        q_reg <= '1;
        r_reg <= bus.i_Dividend;
        sq    <= 1'b0;
        sr    <= 1'b0;
        dbz   <= 1'b1;
      end else if (ovf) begin
        q_reg <= bus.i_Dividend;
        r_reg <= '0;
        sq    <= 1'b0;
        sr    <= 1'b0;
        dbz   <= 1'b0;
      end else begin
        q_reg <= a_mag;
        r_reg <= '0;
        sq    <= a_neg ^ b_neg;
        sr    <= a_neg;
        dbz   <= 1'b0;
      end
    end else if (state == RUN) begin
      if (!t_diff[N]) begin
        r_reg <= t_diff[N-1:0];
        q_reg <= {q_reg[N-2:0], 1'b1};
      end else begin
        r_reg <= r_shift[N-1:0];
        q_reg <= {q_reg[N-2:0], 1'b0};
      end
      cnt <= cnt - CW'(1);
    end else if (state == FIXUP) begin
      bus.o_Quotient  <= sq ? -q_reg : q_reg;
      bus.o_Remainder <= sr ? -r_reg : r_reg;
      bus.o_DivByZero <= dbz;
    end
  end

endmodule

// File: tb/tb_restoring_divider_n.sv
// Directed bench for restoring_divider_n.
// Vector table plus handshake and reset sequences.
module tb_restoring_divider_n;

  logic clk;
  logic rst;
  int   passed;
  int   total;

  restoring_divider_n_if #(.N(32)) dif ();

  restoring_divider_n #(.N(32)) dut (
    .i_Clock (clk),
    .i_Reset (rst),
    .bus     (dif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        s;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    logic        z;
    int          lat;
  } vec_t;

  vec_t vt[10];

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h",
                  name, act, exp);
  endtask

  task automatic do_op(input logic s,
                       input logic [31:0] a,
                       input logic [31:0] b,
                       output int lat,
                       output int busy_n);
    @(negedge clk);
    dif.i_Start    = 1'b1;
    dif.i_Signed   = s;
    dif.i_Dividend = a;
    dif.i_Divisor  = b;
    @(posedge clk);
    #1;
    dif.i_Start = 1'b0;
    lat    = 0;
    busy_n = 0;
    while (!dif.o_Done && lat < 200) begin
      if (dif.o_Busy) busy_n++;
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  initial begin
    int lat;
    int busy_n;
    int dones;
    int first_lat;
    int held_bad;

    passed = 0;
    total  = 0;

    vt[0] = '{1'b0, 32'd100, 32'd7,
              32'd14, 32'd2, 1'b0, 33};
    vt[1] = '{1'b1, 32'hFFFFFFF9, 32'd2,
              32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 33};
    vt[2] = '{1'b1, 32'd7, 32'hFFFFFFFE,
              32'hFFFFFFFD, 32'd1, 1'b0, 33};
    vt[3] = '{1'b0, 32'h12345678, 32'd0,
              32'hFFFFFFFF, 32'h12345678, 1'b1, 1};
    vt[4] = '{1'b1, 32'h12345678, 32'd0,
              32'hFFFFFFFF, 32'h12345678, 1'b1, 1};
    vt[5] = '{1'b1, 32'h80000000, 32'hFFFFFFFF,
              32'h80000000, 32'd0, 1'b0, 1};
    vt[6] = '{1'b0, 32'h80000000, 32'hFFFFFFFF,
              32'd0, 32'h80000000, 1'b0, 33};
    vt[7] = '{1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9,
              32'd14, 32'hFFFFFFFE, 1'b0, 33};
    vt[8] = '{1'b0, 32'hFFFFFFFF, 32'd1,
              32'hFFFFFFFF, 32'd0, 1'b0, 33};
    vt[9] = '{1'b1, 32'hFFFFFFF9, 32'd0,
              32'hFFFFFFFF, 32'hFFFFFFF9, 1'b1, 1};

    dif.i_Start    = 1'b0;
    dif.i_Signed   = 1'b0;
    dif.i_Dividend = '0;
    dif.i_Divisor  = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_q",    dif.o_Quotient, 32'd0);
    check("rst_r",    dif.o_Remainder, 32'd0);
    check("rst_dbz",  32'(dif.o_DivByZero), 32'd0);
    check("rst_busy", 32'(dif.o_Busy), 32'd0);
    check("rst_done", 32'(dif.o_Done), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      do_op(vt[i].s, vt[i].a, vt[i].b, lat, busy_n);
      check($sformatf("v%0d_q", i),
            dif.o_Quotient, vt[i].q);
      check($sformatf("v%0d_r", i),
            dif.o_Remainder, vt[i].r);
      check($sformatf("v%0d_dbz", i),
            32'(dif.o_DivByZero), 32'(vt[i].z));
      check($sformatf("v%0d_lat", i),
            32'(lat), 32'(vt[i].lat));
      check($sformatf("v%0d_busy", i),
            32'(busy_n), 32'(vt[i].lat));
      check($sformatf("v%0d_busy_at_done", i),
            32'(dif.o_Busy), 32'd0);
    end

    // Reset in the middle of a run.
    @(negedge clk);
    dif.i_Start    = 1'b1;
    dif.i_Signed   = 1'b0;
    dif.i_Dividend = 32'd100;
    dif.i_Divisor  = 32'd7;
    @(posedge clk);
    #1;
    dif.i_Start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("mid_rst_q",    dif.o_Quotient, 32'd0);
    check("mid_rst_r",    dif.o_Remainder, 32'd0);
    check("mid_rst_dbz",  32'(dif.o_DivByZero), 32'd0);
    check("mid_rst_busy", 32'(dif.o_Busy), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    dones = 0;
    for (int e = 0; e < 40; e++) begin
      @(posedge clk);
      #1;
      if (dif.o_Done) dones++;
    end
    check("mid_rst_no_done", 32'(dones), 32'd0);
    do_op(1'b0, 32'd100, 32'd7, lat, busy_n);
    check("post_rst_q",   dif.o_Quotient, 32'd14);
    check("post_rst_r",   dif.o_Remainder, 32'd2);
    check("post_rst_lat", 32'(lat), 32'd33);

    // Starts while busy are ignored.
    @(negedge clk);
    dif.i_Start    = 1'b1;
    dif.i_Signed   = 1'b0;
    dif.i_Dividend = 32'd1000;
    dif.i_Divisor  = 32'd10;
    @(posedge clk);
    #1;
    dif.i_Start = 1'b0;
    dones     = 0;
    first_lat = 0;
    for (int e = 1; e <= 50; e++) begin
      if (e == 5 || e == 20) begin
        dif.i_Start    = 1'b1;
        dif.i_Dividend = 32'd5;
        dif.i_Divisor  = 32'd1;
      end
      @(posedge clk);
      #1;
      dif.i_Start = 1'b0;
      if (dif.o_Done) begin
        dones++;
        if (dones == 1) first_lat = e;
      end
    end
    check("ign_dones", 32'(dones), 32'd1);
    check("ign_lat",   32'(first_lat), 32'd33);
    check("ign_q",     dif.o_Quotient, 32'd100);
    check("ign_r",     dif.o_Remainder, 32'd0);

    // Back-to-back: accept during the done cycle.
    do_op(1'b0, 32'd100, 32'd7, lat, busy_n);
    check("b2b_first_lat", 32'(lat), 32'd33);
    dif.i_Start    = 1'b1;
    dif.i_Signed   = 1'b0;
    dif.i_Dividend = 32'd9;
    dif.i_Divisor  = 32'd3;
    @(posedge clk);
    #1;
    dif.i_Start = 1'b0;
    check("b2b_busy", 32'(dif.o_Busy), 32'd1);
    lat      = 0;
    held_bad = 0;
    while (!dif.o_Done && lat < 200) begin
      if (dif.o_Quotient !== 32'd14 ||
          dif.o_Remainder !== 32'd2)
        held_bad++;
      @(posedge clk);
      #1;
      lat++;
    end
    check("b2b_held", 32'(held_bad), 32'd0);
    check("b2b_lat",  32'(lat), 32'd33);
    check("b2b_q",    dif.o_Quotient, 32'd3);
    check("b2b_r",    dif.o_Remainder, 32'd0);
    check("b2b_dbz",  32'(dif.o_DivByZero), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/restoring_divider_n.md
# restoring_divider_N

Multi-cycle N-bit integer divider for the haze-cpu execute stage, serving DIV/DIVU/REM/REMU. It is the arithmetic counterpart of the ripple-carry adder: one restoring shift-and-subtract step per clock, with a start/busy/done handshake toward the pipeline stall logic. Signed operands are divided as magnitudes and sign-corrected in a final cycle. Divide-by-zero and signed overflow return fixed results early.

## Interface
- N, default 32, operand/result width (N ≥ 2)
- i_Clock  input  1  rising-edge clock
- i_Reset  input  1  asynchronous, active-high reset
- i_Start  input  1  request; accepted on a rising edge only when o_Busy = 0
- i_Signed  input  1  1 = two's-complement operands, 0 = unsigned; sampled at accept
- i_Dividend  input  N  sampled at accept
- i_Divisor  input  N  sampled at accept
- o_Busy  output  1  operation in flight; new i_Start ignored
- o_Done  output  1  one-cycle pulse; results valid
- o_Quotient  output  N  registered quotient, held until next o_Done
- o_Remainder  output  N  registered remainder, held until next o_Done
- o_DivByZero  output  1  registered flag for last result, held with results

## Operation
- States: IDLE, RUN, FIXUP, DONE. DONE behaves as IDLE for acceptance; it is present only to drive o_Done.
- Accept in IDLE/DONE with i_Start = 1:
  - Latch sign flags: sQ = sign(A) xor sign(B), sR = sign(A), both only when i_Signed.
  - Latch |A| into the quotient shift register Q and |B| into D.
  - Clear the N+1-bit partial remainder R and set the step counter to N.
  - Go to RUN.
- Early exits at accept, which go to FIXUP instead of RUN:
  - Divisor = 0: quotient = all ones, remainder = dividend (raw), o_DivByZero = 1.
  - i_Signed and A = 100…0 and B = all ones: quotient = A, remainder = 0.
- RUN step:
  - R' = {R[N-1:0], Q[N-1]}.
  - T = R' − {0, D}, computed at N+1 bits.
  - If T[N] = 0: R ← T and Q ← {Q[N-2:0], 1}. Otherwise R ← R' and Q ← {Q[N-2:0], 0}.
  - Decrement the counter and go to FIXUP after the Nth step.
- FIXUP:
  - o_Quotient ← sQ ? −Q : Q.
  - o_Remainder ← sR ? −R[N-1:0] : R[N-1:0].
  - o_DivByZero ← 0, unless an early exit applied.
  - Go to DONE.
- DONE: assert o_Done. Go to RUN if a new accept occurs, otherwise to IDLE.
- All negations and subtractions are modulo 2^N, except T, which is N+1 bits. Unsigned mode performs no sign handling.

## Timing
- Reset asynchronously forces:
  - state = IDLE
  - o_Busy = 0, o_Done = 0
  - o_Quotient = 0, o_Remainder = 0, o_DivByZero = 0
  - all internal registers cleared
- Normal path, accept at edge 0:
  - RUN steps occur at edges 1..N.
  - FIXUP writes the results at edge N+1.
  - o_Done = 1 for the cycle after edge N+1, which is N+1 clocks of latency.
- Early-exit path: results are written at edge 1, and o_Done is high for the cycle after edge 1.
- o_Busy is 1 from after the accept edge until the edge on which o_Done rises, and 0 while o_Done = 1.
- i_Start during o_Busy = 1 is ignored. It is not queued.
- i_Start during the o_Done cycle is accepted, giving back-to-back operations with no idle cycle. The outputs of the completed operation remain held until the next FIXUP.
- Input ports are don't-care except at the accept edge.
- Reset asserted mid-operation aborts it. No o_Done is produced and the outputs return to 0.

## Test plan
- Unsigned, N=32, A=100, B=7, start at edge 0 → o_Done after edge 33; quotient 14, remainder 2, o_DivByZero 0; o_Busy high exactly 33 cycles.
- Signed, A=−7 (0xFFFFFFF9), B=2 → quotient 0xFFFFFFFD (−3), remainder 0xFFFFFFFF (−1). Repeat with A=7, B=−2 → quotient 0xFFFFFFFD, remainder 1.
- Divide by zero: A=0x12345678, B=0, either mode → o_Done after edge 1; quotient 0xFFFFFFFF, remainder 0x12345678, o_DivByZero 1.
- Signed overflow: A=0x80000000, B=0xFFFFFFFF → o_Done after edge 1; quotient 0x80000000, remainder 0. The same operands unsigned → quotient 0, remainder 0x80000000, full latency.
- Handshake:
  - i_Start pulses at edges 5 and 20 after an accept at edge 0 are ignored, and exactly one o_Done occurs.
  - i_Start during the o_Done cycle with A=9, B=3 → a second o_Done 33 clocks later with quotient 3, remainder 0. The first results stay held in between.
- Reset at edge 10 of a run → all outputs 0 immediately and no o_Done. A new start after reset release completes correctly.
